sad_result_capture: RTL and testbench

Downstream consumer of the pipelined SAD datapath top level: watches the processor's v0/v1 result registers every cycle and records each distinct result pair in a sequence-numbered FIFO. A downstream reader (display driver, bench scoreboard) drains the FIFO over a valid/ready handshake. A stability detector flags completion once the results stop changing.

---
 rtl/sad_result_capture.sv | 188 ++++++++++++++++++
 tb/tb_sad_result_capture.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sad_result_capture.sv
// sad_result_capture
//   Watches the SAD datapath v0/v1 result registers, records every distinct
//   result pair into a sequence-numbered show-ahead FIFO drained over a
//   valid/ready handshake, and flags completion once results stop changing.
//   Optional feature macro: CAPTURE_TIMESTAMP_EN (adds a 16-bit push
//   timestamp per entry and the out_ts port).
module sad_result_capture #(
  parameter int WIDTH         = 32,
  parameter int DEPTH         = 8,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         v0in,
  input  logic [WIDTH-1:0]         v1in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_v0,
  output logic [WIDTH-1:0]         out_v1,
  output logic [7:0]               out_seq,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     done
`ifdef CAPTURE_TIMESTAMP_EN
  ,
  output logic [15:0]              out_ts
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [7:0]  CNT_LAST = 8'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, TRACK, DONE} state_t;

  logic [WIDTH-1:0] s_v0, s_v1, p_v0, p_v1;
  logic             s_vld;
  logic             chg;
  logic [7:0]       seq;

  logic [WIDTH-1:0] mem_v0  [DEPTH];
  logic [WIDTH-1:0] mem_v1  [DEPTH];
  logic [7:0]       mem_seq [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             full, pop, wr_en, drop;

  state_t           state, state_nxt;
  logic [7:0]       cnt, cnt_nxt;

`ifdef CAPTURE_TIMESTAMP_EN
  logic [15:0]      ts;
  logic [15:0]      mem_ts [DEPTH];
`endif

  assign chg       = s_vld & ({s_v0, s_v1} != {p_v0, p_v1});
  assign out_valid = (count != '0);
  assign full      = (count == FULL_LVL);
  assign pop       = out_valid & out_ready;
  // a full FIFO still accepts the push when the head leaves in the same cycle
  assign wr_en     = chg & (~full | pop);
  assign drop      = chg & full & ~pop;

  assign out_v0    = mem_v0[rd_ptr];
  assign out_v1    = mem_v1[rd_ptr];
  assign out_seq   = mem_seq[rd_ptr];
  assign level     = count;
  assign done      = (state == DONE);
`ifdef CAPTURE_TIMESTAMP_EN
  assign out_ts    = mem_ts[rd_ptr];
`endif

  // sample stage and last-recorded pair used by the change detector
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_v0  <= '0;
      s_v1  <= '0;
      s_vld <= 1'b0;
      p_v0  <= '0;
      p_v1  <= '0;
    end else begin
      s_v0  <= v0in;
      s_v1  <= v1in;
      s_vld <= 1'b1;
      if (chg) begin
        p_v0 <= s_v0;
        p_v1 <= s_v1;
      end
    end
  end

  // sequence number advances on every change, even a dropped one
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seq      <= '0;
      overflow <= 1'b0;
    end else begin
      if (chg)  seq      <= seq + 8'd1;
      if (drop) overflow <= 1'b1;
    end
  end

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_v0[i]  <= '0;
        mem_v1[i]  <= '0;
        mem_seq[i] <= '0;
`ifdef CAPTURE_TIMESTAMP_EN
        mem_ts[i]  <= '0;
`endif
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem_v0[wr_ptr]  <= s_v0;
        mem_v1[wr_ptr]  <= s_v1;
        mem_seq[wr_ptr] <= seq;
`ifdef CAPTURE_TIMESTAMP_EN
        mem_ts[wr_ptr]  <= ts;
`endif
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef CAPTURE_TIMESTAMP_EN
  // free-running cycle counter for entry timestamps
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ts <= '0;
    else      ts <= ts + 16'd1;
  end
`endif

  // stability FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // stability FSM next-state: count unchanged cycles after the last change
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (chg) begin
          state_nxt = TRACK;
          cnt_nxt   = '0;
        end
      end
      TRACK: begin
        if (chg) begin
          cnt_nxt = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
        end
      end
      DONE: begin
        if (chg) begin
          state_nxt = TRACK;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_sad_result_capture.sv
// Testbench for sad_result_capture: directed table, hand-written corner
// sequences and randomized stimulus checked against a queue-based model.
module tb_sad_result_capture;

  localparam int W = 32;
  localparam int D = 8;
  localparam int S = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] v0in, v1in;
  logic         out_valid, out_ready;
  logic [W-1:0] out_v0, out_v1;
  logic [7:0]   out_seq;
  logic [3:0]   level;
  logic         overflow, done;
`ifdef CAPTURE_TIMESTAMP_EN
  logic [15:0]  out_ts;
`endif

  sad_result_capture #(.WIDTH(W), .DEPTH(D), .STABLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .v0in(v0in), .v1in(v1in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_v0(out_v0), .out_v1(out_v1), .out_seq(out_seq),
    .level(level), .overflow(overflow), .done(done)
`ifdef CAPTURE_TIMESTAMP_EN
    , .out_ts(out_ts)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0]   seq;
    logic [W-1:0] v0;
    logic [W-1:0] v1;
    logic [15:0]  ts;
  } ent_t;

  ent_t         q[$];
  logic [W-1:0] m_last0, m_last1, m_pend0, m_pend1;
  bit           m_pend_vld;
  logic [7:0]   m_seq;
  bit           m_ovf;
  bit           m_have;
  int           m_since;
  int unsigned  m_edges;

  task automatic model_reset();
    q.delete();
    m_last0 = '0; m_last1 = '0;
    m_pend0 = '0; m_pend1 = '0;
    m_pend_vld = 0;
    m_seq = '0;
    m_ovf = 0;
    m_have = 0;
    m_since = 0;
    m_edges = 0;
  endtask

  // one clock edge: inputs/ready are the values present just before the edge
  task automatic model_edge(input logic [W-1:0] a, input logic [W-1:0] b, input logic r);
    bit   do_pop;
    bit   do_chg;
    ent_t e;
    do_pop = (q.size() > 0) && r;
    do_chg = m_pend_vld && ((m_pend0 != m_last0) || (m_pend1 != m_last1));
    if (do_pop) void'(q.pop_front());
    if (do_chg) begin
      if (q.size() < D) begin
        e.seq = m_seq; e.v0 = m_pend0; e.v1 = m_pend1; e.ts = m_edges[15:0];
        q.push_back(e);
      end else begin
        m_ovf = 1;
      end
      m_seq   = m_seq + 8'd1;
      m_last0 = m_pend0;
      m_last1 = m_pend1;
      m_have  = 1;
      m_since = 0;
    end else if (m_have && m_since < 100000) begin
      m_since++;
    end
    m_pend0 = a; m_pend1 = b; m_pend_vld = 1;
    m_edges++;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("level",     64'(level),     64'(q.size()));
    chk("overflow",  64'(overflow),  64'(m_ovf));
    chk("done",      64'(done),      64'(m_have && (m_since >= S)));
    if (q.size() != 0) begin
      chk("out_seq", 64'(out_seq), 64'(q[0].seq));
      chk("out_v0",  64'(out_v0),  64'(q[0].v0));
      chk("out_v1",  64'(out_v1),  64'(q[0].v1));
`ifdef CAPTURE_TIMESTAMP_EN
      chk("out_ts",  64'(out_ts),  64'(q[0].ts));
`endif
    end
  endtask

  task automatic step(input logic [W-1:0] a, input logic [W-1:0] b, input logic r);
    v0in = a; v1in = b; out_ready = r;
    @(posedge clk);
    model_edge(a, b, r);
    #1;
    compare_all();
  endtask

  // called at posedge+1; releases reset before the next edge
  task automatic do_reset();
    rst = 1'b0;
    v0in = '0; v1in = '0; out_ready = 1'b0;
    model_reset();
    #2;
    compare_all();
    chk("rst_out_v0",  64'(out_v0),  64'd0);
    chk("rst_out_v1",  64'(out_v1),  64'd0);
    chk("rst_out_seq", 64'(out_seq), 64'd0);
    #3;
    rst = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [W-1:0] v0;
    logic [W-1:0] v1;
    logic         rdy;
    logic         ev;
    int           el;
    logic         eo;
    logic [7:0]   es;
  } vec_t;

  vec_t tbl[$];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t         vr;
    logic [15:0]  ts1, ts2;
    logic [W-1:0] ra, rb;
    int           seglen;

    // table for the overflow / drain / seq-gap scenario
    for (int i = 1; i <= 10; i++) begin
      vr.v0 = W'(i); vr.v1 = W'(32'h100 + i); vr.rdy = 0;
      vr.ev = (i >= 2); vr.el = (i - 1 > 8) ? 8 : i - 1; vr.eo = (i >= 10); vr.es = 8'd0;
      tbl.push_back(vr);
    end
    for (int i = 11; i <= 12; i++) begin
      vr.v0 = 32'd10; vr.v1 = 32'h10A; vr.rdy = 0;
      vr.ev = 1; vr.el = 8; vr.eo = 1; vr.es = 8'd0;
      tbl.push_back(vr);
    end
    for (int j = 1; j <= 8; j++) begin
      vr.v0 = 32'd10; vr.v1 = 32'h10A; vr.rdy = 1;
      vr.ev = (j < 8); vr.el = 8 - j; vr.eo = 1; vr.es = 8'(j);
      tbl.push_back(vr);
    end
    vr.v0 = 32'hAA; vr.v1 = 32'hBB; vr.rdy = 0;
    vr.ev = 0; vr.el = 0; vr.eo = 1; vr.es = 8'd0;
    tbl.push_back(vr);
    vr.ev = 1; vr.el = 1; vr.eo = 1; vr.es = 8'd10;
    tbl.push_back(vr);
    tbl.push_back(vr);

    rst = 1'b0; v0in = '0; v1in = '0; out_ready = 1'b0;
    model_reset();
    @(posedge clk); #1;

    // all-zero stream never produces an entry nor completes
    do_reset();
    for (int i = 0; i < 50; i++) step('0, '0, 1'($urandom_range(0, 1)));
    chk("zero_valid", 64'(out_valid), 64'd0);
    chk("zero_done",  64'(done),      64'd0);

    // latency of a single change and done timing
    do_reset();
    for (int i = 0; i < 9; i++) step('0, '0, 1'b0);
    step(32'h5, 32'h3, 1'b0);
    chk("lat_valid_early", 64'(out_valid), 64'd0);
    step(32'h5, 32'h3, 1'b0);
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("lat_v0",    64'(out_v0),    64'd5);
    chk("lat_v1",    64'(out_v1),    64'd3);
    chk("lat_seq",   64'(out_seq),   64'd0);
    for (int i = 0; i < S - 1; i++) step(32'h5, 32'h3, 1'b0);
    chk("done_early", 64'(done), 64'd0);
    step(32'h5, 32'h3, 1'b0);
    chk("done_rise", 64'(done), 64'd1);
    step(32'h6, 32'h3, 1'b0);
    chk("done_hold", 64'(done), 64'd1);
    step(32'h6, 32'h3, 1'b0);
    chk("done_fall", 64'(done), 64'd0);

    // overflow, drain order and sequence gap
    do_reset();
    foreach (tbl[k]) begin
      step(tbl[k].v0, tbl[k].v1, tbl[k].rdy);
      chk("tbl_valid", 64'(out_valid), 64'(tbl[k].ev));
      chk("tbl_level", 64'(level),     64'(tbl[k].el));
      chk("tbl_ovf",   64'(overflow),  64'(tbl[k].eo));
      if (tbl[k].ev) chk("tbl_seq", 64'(out_seq), 64'(tbl[k].es));
    end

    // full FIFO with a simultaneous pop accepts the push
    do_reset();
    for (int i = 1; i <= 9; i++) step(W'(i), W'(i), 1'b0);
    chk("full_level", 64'(level), 64'd8);
    step(32'd9, 32'd9, 1'b1);
    chk("fullpp_level", 64'(level),    64'd8);
    chk("fullpp_ovf",   64'(overflow), 64'd0);
    chk("fullpp_seq",   64'(out_seq),  64'd1);
    step(32'd9, 32'd9, 1'b0);

    // asynchronous reset mid-operation
    do_reset();
    for (int i = 1; i <= 5; i++) step(W'(32'h50 + i), 32'h7, 1'b0);
    for (int i = 0; i < 20; i++) step(32'h55, 32'h7, 1'b0);
    chk("pre_rst_level", 64'(level), 64'd5);
    chk("pre_rst_done",  64'(done),  64'd1);
    rst = 1'b0;
    #1;
    chk("arst_level", 64'(level),     64'd0);
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_done",  64'(done),      64'd0);
    model_reset();
    #4;
    rst = 1'b1;
    step(32'h55, 32'h7, 1'b0);
    step(32'h55, 32'h7, 1'b0);
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_seq",   64'(out_seq),   64'd0);

`ifdef CAPTURE_TIMESTAMP_EN
    // timestamps of pushes at edges 12 and 40
    do_reset();
    for (int i = 0; i < 10; i++) step('0, '0, 1'b0);
    step(32'd1, 32'd1, 1'b0);
    step(32'd1, 32'd1, 1'b0);
    ts1 = out_ts;
    for (int i = 0; i < 26; i++) step(32'd1, 32'd1, 1'b1);
    step(32'd2, 32'd2, 1'b0);
    step(32'd2, 32'd2, 1'b0);
    ts2 = out_ts;
    chk("ts_delta", 64'(16'(ts2 - ts1)), 64'd28);
`else
    ts1 = '0; ts2 = '0;
`endif

    // randomized segments checked against the model
    do_reset();
    ra = '0; rb = '0;
    for (int n = 0; n < 3000; ) begin
      case ($urandom_range(0, 3))
        0:       begin ra = '0; rb = '0; end
        1:       begin ra = $urandom; rb = $urandom; end
        default: begin ra = W'($urandom_range(0, 3)); rb = W'($urandom_range(0, 3)); end
      endcase
      seglen = ($urandom_range(0, 5) == 0) ? $urandom_range(15, 30) : $urandom_range(1, 4);
      for (int k = 0; k < seglen; k++) begin
        step(ra, rb, 1'($urandom_range(0, 2) == 0));
        n++;
      end
      if ($urandom_range(0, 150) == 0) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
